// File: rtl/riscv_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_responder_pkg
//  Brief    : Shared data width, byte-select encodings, FSM states and
//             lane helpers for the data-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_dmem_responder_pkg;

  localparam int c_XLEN = 32;

  // Lane-enable patterns the core may legally issue
  localparam logic [3:0] c_BSEL_B0 = 4'b0001;
  localparam logic [3:0] c_BSEL_B1 = 4'b0010;
  localparam logic [3:0] c_BSEL_B2 = 4'b0100;
  localparam logic [3:0] c_BSEL_B3 = 4'b1000;
  localparam logic [3:0] c_BSEL_H0 = 4'b0011;
  localparam logic [3:0] c_BSEL_H1 = 4'b1100;
  localparam logic [3:0] c_BSEL_W  = 4'b1111;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Only naturally aligned byte, halfword and word accesses are legal
  function automatic logic bsel_legal(input logic [3:0] sel);
    logic ok;
    ok = 1'b0;
    case (sel)
      c_BSEL_B0, c_BSEL_B1, c_BSEL_B2, c_BSEL_B3,
      c_BSEL_H0, c_BSEL_H1, c_BSEL_W: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Expand the 4 lane enables into a 32-bit data mask
  function automatic logic [c_XLEN-1:0] bsel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_responder_array.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_array
//  Brief    : DEPTH_WORDS x 32-bit synchronous RAM built from four byte lanes,
//             per-lane write enable and a registered read port.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_dmem_array
  import riscv_dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              i_clk,
  input  logic [3:0]        i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [c_XLEN-1:0] i_wdata,
  output logic [c_XLEN-1:0] o_rdata
);

  // One independent storage array per byte lane keeps each lane's write enable local
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_q;

    // Lane write and registered read; contents are intentionally not reset
    always_ff @(posedge i_clk) begin
      if (i_we[g]) begin
        r_mem[i_addr] <= i_wdata[8*g +: 8];
      end
      if (i_re) begin
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_responder
//  Brief    : Responder side of the core's data-memory port. Accepts one
//             request per handshake, waits WAIT_CYCLES, commits to the RAM and
//             returns a single-cycle response with read data / error flag.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [c_XLEN-1:0] BASE_ADDR   = 32'h0,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr_en,
  input  logic [c_XLEN-1:0] i_req_addr,
  input  logic [3:0]        i_req_byte_sel,
  input  logic [c_XLEN-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [c_XLEN-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam bit         c_NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_CNT_INIT = c_NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e       r_state;
  logic              r_req_ready;
  logic [3:0]        r_cnt;
  logic              r_req_wr;
  logic [c_XLEN-1:0] r_req_addr;
  logic [3:0]        r_req_sel;
  logic [c_XLEN-1:0] r_req_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_wr;
  logic [3:0]        r_rsp_sel;

  logic              w_accept;
  logic              w_commit;
  logic              w_op_wr;
  logic [c_XLEN-1:0] w_op_addr;
  logic [3:0]        w_op_sel;
  logic [c_XLEN-1:0] w_op_wdata;
  logic [c_XLEN-1:0] w_off;
  logic              w_below;
  logic              w_above;
  logic              w_err;
  logic [c_IDX_W-1:0] w_idx;
  logic              w_ram_en;
  logic [3:0]        w_we;
  logic              w_re;
  logic [c_XLEN-1:0] w_ram_rdata;
  logic              w_unused_lsbs;

  assign w_accept = i_req_valid & r_req_ready;

  // With no wait states the RAM is touched on the accept edge itself, so the
  // live request is used; otherwise the latched copy is used on the last WAIT edge.
  assign w_op_wr    = c_NO_WAIT ? i_req_wr_en    : r_req_wr;
  assign w_op_addr  = c_NO_WAIT ? i_req_addr     : r_req_addr;
  assign w_op_sel   = c_NO_WAIT ? i_req_byte_sel : r_req_sel;
  assign w_op_wdata = c_NO_WAIT ? i_req_wdata    : r_req_wdata;
  assign w_commit   = c_NO_WAIT ? w_accept
                                : ((r_state == DMEM_WAIT) && (r_cnt == 4'd0));

  // Range and lane checks; depth is a power of two so any bit above the index is out of range
  assign w_off         = w_op_addr - BASE_ADDR;
  assign w_below       = (w_op_addr < BASE_ADDR);
  assign w_above       = |w_off[c_XLEN-1:c_IDX_W+2];
  assign w_err         = w_below | w_above | ~bsel_legal(w_op_sel);
  assign w_idx         = w_off[c_IDX_W+1:2];
  assign w_unused_lsbs = ^w_off[1:0];

  // Reset on the commit edge drops the access entirely
  assign w_ram_en = w_commit & ~i_rst & ~w_err;
  assign w_we     = (w_ram_en & w_op_wr) ? w_op_sel : 4'b0000;
  assign w_re     = w_ram_en & ~w_op_wr;

  riscv_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_idx),
    .i_wdata (w_op_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Request FSM: latch on accept, count wait states, strobe the response for one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= DMEM_IDLE;
      r_req_ready <= 1'b1;
      r_cnt       <= 4'd0;
      r_req_wr    <= 1'b0;
      r_req_addr  <= '0;
      r_req_sel   <= 4'b0000;
      r_req_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_wr    <= 1'b0;
      r_rsp_sel   <= 4'b0000;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        DMEM_IDLE, DMEM_RESP: begin
          if (w_accept) begin
            r_req_wr    <= i_req_wr_en;
            r_req_addr  <= i_req_addr;
            r_req_sel   <= i_req_byte_sel;
            r_req_wdata <= i_req_wdata;
            if (c_NO_WAIT) begin
              r_state     <= DMEM_RESP;
              r_req_ready <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_rsp_wr    <= w_op_wr;
              r_rsp_sel   <= w_op_sel;
            end else begin
              r_state     <= DMEM_WAIT;
              r_cnt       <= c_CNT_INIT;
              r_req_ready <= 1'b0;
            end
          end else begin
            r_state     <= DMEM_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        DMEM_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= DMEM_RESP;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_wr    <= w_op_wr;
            r_rsp_sel   <= w_op_sel;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state     <= DMEM_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_valid & r_rsp_err;
  assign o_rsp_rdata = (r_rsp_valid & ~r_rsp_err & ~r_rsp_wr)
                       ? (w_ram_rdata & bsel_mask(r_rsp_sel)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_dmem_responder
//  Brief    : Directed bench for riscv_dmem_responder; one instance with one
//             wait state at base 0, one with no wait states at base 0x1000.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WAIT_CYCLES=1, BASE 0, 1024 words
  logic        a_rst, a_valid, a_ready, a_wr, a_rsp_valid, a_rsp_err;
  logic [31:0] a_addr, a_wdata, a_rsp_rdata;
  logic [3:0]  a_sel;
  // Instance B: WAIT_CYCLES=0, BASE 0x1000, 256 words
  logic        b_rst, b_valid, b_ready, b_wr, b_rsp_valid, b_rsp_err;
  logic [31:0] b_addr, b_wdata, b_rsp_rdata;
  logic [3:0]  b_sel;

  riscv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_req_valid(a_valid), .o_req_ready(a_ready),
    .i_req_wr_en(a_wr), .i_req_addr(a_addr), .i_req_byte_sel(a_sel),
    .i_req_wdata(a_wdata), .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rsp_rdata),
    .o_rsp_err(a_rsp_err)
  );

  riscv_dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_req_valid(b_valid), .o_req_ready(b_ready),
    .i_req_wr_en(b_wr), .i_req_addr(b_addr), .i_req_byte_sel(b_sel),
    .i_req_wdata(b_wdata), .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata),
    .o_rsp_err(b_rsp_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full request on instance A: wait for ready, accept, then wait for the response
  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output logic rdy_after, output int lat);
    int n;
    a_valid = 1'b1; a_wr = wr; a_addr = addr; a_sel = sel; a_wdata = wd;
    n = 0;
    while (!a_ready && n < 20) begin step(); n++; end
    if (n >= 20) chk("a_accept_timeout", 32'd0, 32'd1);
    step();
    a_valid = 1'b0;
    rdy_after = a_ready;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin step(); lat++; end
    if (lat >= 20) chk("a_rsp_timeout", 32'd0, 32'd1);
    rd = a_rsp_rdata;
    er = a_rsp_err;
    step();
    chk("a_rsp_one_cycle", {31'd0, a_rsp_valid}, 32'd0);
  endtask

  // Single-cycle request on instance B; the response appears right after the accept edge
  task automatic req_b(input logic wr, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    b_valid = 1'b1; b_wr = wr; b_addr = addr; b_sel = sel; b_wdata = wd;
    chk("b_ready_before", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    chk("b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    rd = b_rsp_rdata;
    er = b_rsp_err;
  endtask

  logic [31:0] rd;
  logic        er, rdy;
  int          lat;
  logic        acc_now, acc_prev;
  int          n_acc, n_rsp;

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_sel = '0; a_wdata = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_sel = '0; b_wdata = '0;
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    chk("a_rst_ready", {31'd0, a_ready}, 32'd1);
    chk("a_rst_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("a_rst_rdata", a_rsp_rdata, 32'd0);
    chk("a_rst_err",   {31'd0, a_rsp_err}, 32'd0);
    chk("b_rst_ready", {31'd0, b_ready}, 32'd1);
    chk("b_rst_valid", {31'd0, b_rsp_valid}, 32'd0);

    // ---------------- Instance A (one wait state) ----------------
    req_a(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er, rdy, lat);
    chk("a_st_ready_low", {31'd0, rdy}, 32'd0);
    chk("a_st_latency",   lat, 32'd1);
    chk("a_st_err",       {31'd0, er}, 32'd0);
    chk("a_st_rdata",     rd, 32'd0);

    req_a(1'b0, 32'h10, 4'b0100, 32'h0, rd, er, rdy, lat);
    chk("a_ld_b2",     rd, 32'h00AD0000);
    chk("a_ld_b2_err", {31'd0, er}, 32'd0);

    req_a(1'b1, 32'h10, 4'b0011, 32'h00001234, rd, er, rdy, lat);
    req_a(1'b0, 32'h10, 4'b1111, 32'h0, rd, er, rdy, lat);
    chk("a_ld_merged", rd, 32'hDEAD1234);

    req_a(1'b0, 32'h13, 4'b1000, 32'h0, rd, er, rdy, lat);
    chk("a_ld_b3_addr_lsb_ignored", rd, 32'hDE000000);

    // Out of range (one past the last word) and illegal lane patterns
    req_a(1'b0, 32'h1000, 4'b1111, 32'h0, rd, er, rdy, lat);
    chk("a_oor_err",   {31'd0, er}, 32'd1);
    chk("a_oor_rdata", rd, 32'd0);
    chk("a_oor_lat",   lat, 32'd1);

    req_a(1'b0, 32'hFFC, 4'b1111, 32'h0, rd, er, rdy, lat);
    chk("a_last_word_ok", {31'd0, er}, 32'd0);

    req_a(1'b1, 32'h0, 4'b1111, 32'h11223344, rd, er, rdy, lat);
    req_a(1'b1, 32'h0, 4'b0101, 32'hFFFFFFFF, rd, er, rdy, lat);
    chk("a_bsel0101_st_err", {31'd0, er}, 32'd1);
    req_a(1'b0, 32'h0, 4'b0101, 32'h0, rd, er, rdy, lat);
    chk("a_bsel0101_ld_err",   {31'd0, er}, 32'd1);
    chk("a_bsel0101_ld_rdata", rd, 32'd0);
    req_a(1'b1, 32'h10, 4'b0000, 32'h0, rd, er, rdy, lat);
    chk("a_bsel0000_err", {31'd0, er}, 32'd1);
    req_a(1'b0, 32'h0, 4'b1111, 32'h0, rd, er, rdy, lat);
    chk("a_unchanged_0", rd, 32'h11223344);
    req_a(1'b0, 32'h10, 4'b1111, 32'h0, rd, er, rdy, lat);
    chk("a_unchanged_10", rd, 32'hDEAD1234);

    // Reset while a store sits in WAIT: store dropped, no response
    req_a(1'b1, 32'h30, 4'b1111, 32'hCAFEF00D, rd, er, rdy, lat);
    a_valid = 1'b1; a_wr = 1'b1; a_addr = 32'h30; a_sel = 4'b1111; a_wdata = 32'h0BADBEEF;
    step();
    a_valid = 1'b0;
    chk("a_midrst_in_wait", {31'd0, a_ready}, 32'd0);
    a_rst = 1'b1;
    step();
    chk("a_midrst_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
    a_rst = 1'b0;
    chk("a_midrst_ready", {31'd0, a_ready}, 32'd1);
    step();
    chk("a_midrst_no_rsp2", {31'd0, a_rsp_valid}, 32'd0);
    req_a(1'b0, 32'h30, 4'b1111, 32'h0, rd, er, rdy, lat);
    chk("a_midrst_old_value", rd, 32'hCAFEF00D);

    // Random valid toggling: exactly one response per accept, one edge later
    acc_prev = 1'b0; n_acc = 0; n_rsp = 0;
    for (int i = 0; i < 200; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_wr    = 1'b0;
      a_addr  = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      a_sel   = 4'b1111;
      acc_now = a_valid & a_ready;
      if (acc_now) n_acc++;
      step();
      chk("a_rand_rsp", {31'd0, a_rsp_valid}, {31'd0, acc_prev});
      if (a_rsp_valid) n_rsp++;
      acc_prev = acc_now;
    end
    a_valid = 1'b0;
    step();
    chk("a_rand_rsp_drain", {31'd0, a_rsp_valid}, {31'd0, acc_prev});
    if (a_rsp_valid) n_rsp++;
    chk("a_rand_count", n_rsp, n_acc);

    // ---------------- Instance B (no wait states, base 0x1000) ----------------
    // Store then load back-to-back: load accepted in the store's response cycle
    b_valid = 1'b1; b_wr = 1'b1; b_addr = 32'h1020; b_sel = 4'b1111; b_wdata = 32'hA5A55A5A;
    step();
    chk("b_b2b_st_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_b2b_st_ready", {31'd0, b_ready}, 32'd1);
    chk("b_b2b_st_rdata", b_rsp_rdata, 32'd0);
    b_wr = 1'b0; b_wdata = 32'h0;
    step();
    b_valid = 1'b0;
    chk("b_b2b_ld_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_b2b_ld_rdata", b_rsp_rdata, 32'hA5A55A5A);
    step();
    chk("b_b2b_idle", {31'd0, b_rsp_valid}, 32'd0);
    chk("b_idle_rdata", b_rsp_rdata, 32'd0);

    req_b(1'b0, 32'h1020, 4'b0010, 32'h0, rd, er);
    chk("b_ld_b1", rd, 32'h00005A00);
    req_b(1'b0, 32'h1020, 4'b1100, 32'h0, rd, er);
    chk("b_ld_h1", rd, 32'hA5A50000);
    req_b(1'b0, 32'h0FFC, 4'b1111, 32'h0, rd, er);
    chk("b_below_base_err",   {31'd0, er}, 32'd1);
    chk("b_below_base_rdata", rd, 32'd0);
    req_b(1'b0, 32'h1400, 4'b1111, 32'h0, rd, er);
    chk("b_above_err", {31'd0, er}, 32'd1);
    req_b(1'b1, 32'h13FC, 4'b1000, 32'h7F000000, rd, er);
    chk("b_top_st_ok", {31'd0, er}, 32'd0);
    req_b(1'b0, 32'h13FC, 4'b1000, 32'h0, rd, er);
    chk("b_top_ld", rd, 32'h7F000000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
